axi_sram_slave: RTL and testbench

//  Single-beat AXI4 slave SRAM that terminates the core's io_master_* bus (IFU fetch + LSU load/store).

---
 rtl/axi_sram_slave_pkg.sv | 33 +++
 rtl/axi_sram_slave_if.sv | 70 +++++++
 rtl/axi_sram_slave_lfsr.sv | 32 +++
 rtl/axi_sram_slave.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the single-beat AXI4 SRAM slave.
// Contents: response codes, AxSIZE encodings, read/write FSM state types and an
// address-window helper used to flag out-of-range accesses.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RResp
  } rd_state_t;

  typedef enum logic [1:0] {
    WIdle,
    WDelay,
    WResp
  } wr_state_t;

  // True when addr lies in [base, base + span); 33-bit math avoids wrap at 4 GiB.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return ({1'b0, addr} >= {1'b0, base}) && (off < span);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 single-beat bus bundle between a master (core io_master_*) and the SRAM slave.
// Channels: AW (awvalid/awready/awaddr/awid/awlen/awsize/awburst),
//           W  (wvalid/wready/wdata/wstrb/wlast),
//           B  (bvalid/bready/bresp/bid),
//           AR (arvalid/arready/araddr/arid/arlen/arsize/arburst),
//           R  (rvalid/rready/rdata/rresp/rlast/rid).
// Modports: master drives requests and readys for B/R; slave drives the rest.
interface axi_sram_slave_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

endinterface

// File: rtl/axi_sram_slave_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying pseudo-random response delays.
// Ports: clock (rising edge), reset (async active-low, reloads SEED),
//        step (advance one position), lfsr (current state).
module axi_sram_slave_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] lfsr
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 SRAM slave with pseudo-random AR->R and AW/W->B latency.
// Ports: clock (rising edge), reset (async active-low),
//        io_slave (axi_sram_slave_if.slave: AW, W, B, AR, R channels).
// Reads and writes run in independent FSMs sharing one delay LFSR. Accesses outside
// the mapped window or with len != 0 answer SLVERR and never touch memory.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter bit          DELAY_EN    = 1'b1,
  parameter int unsigned DELAY_MAX   = 7
) (
  input logic              clock,
  input logic              reset,
  axi_sram_slave_if.slave  io_slave
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);
  localparam logic [2:0]  DMASK = 3'(DELAY_MAX);

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0] lfsr;
  logic       lfsr_step;

  // Read channel state
  rd_state_t        rd_state_q, rd_state_d;
  logic [2:0]       rd_cnt_q, rd_cnt_d;
  logic [IDX_W-1:0] rd_idx_q;
  logic             rd_err_q;
  logic [3:0]       rd_id_q;
  logic             arready_q, rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic             rd_load;
  logic             ar_hs;
  logic [2:0]       rd_delay;

  // Write channel state
  wr_state_t        wr_state_q, wr_state_d;
  logic [2:0]       wr_cnt_q, wr_cnt_d;
  logic             aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_err_q;
  logic [3:0]       wr_id_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             awready_q, wready_q, bvalid_q;
  logic [1:0]       bresp_q;
  logic             aw_hs, w_hs, wr_draw, commit;
  logic [2:0]       wr_delay;

  assign ar_hs = io_slave.arvalid & arready_q;
  assign aw_hs = io_slave.awvalid & awready_q;
  assign w_hs  = io_slave.wvalid & wready_q;

  // Write draws its delay on the cycle the second of AW/W is latched.
  assign wr_draw   = (wr_state_q == WIdle) & (aw_have_q | aw_hs) & (w_have_q | w_hs);
  assign lfsr_step = ar_hs | wr_draw;

  // A simultaneous draw gives the read the low bits and the write the next three.
  assign rd_delay = DELAY_EN ? (lfsr[2:0] & DMASK) : 3'd0;
  assign wr_delay = DELAY_EN ? ((ar_hs ? lfsr[5:3] : lfsr[2:0]) & DMASK) : 3'd0;

  axi_sram_slave_lfsr #(
    .SEED (8'hA5)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step),
    .lfsr  (lfsr)
  );

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_load    = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        if (ar_hs) begin
          rd_state_d = RWait;
          rd_cnt_d   = rd_delay;
        end
      end
      RWait: begin
        if (rd_cnt_q == 3'd0) begin
          rd_state_d = RResp;
          rd_load    = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt_q - 3'd1;
        end
      end
      RResp: begin
        if (io_slave.rready) begin
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state_q <= RIdle;
      rd_cnt_q   <= 3'd0;
      rd_idx_q   <= '0;
      rd_err_q   <= 1'b0;
      rd_id_q    <= 4'd0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      arready_q  <= (rd_state_d == RIdle);
      rvalid_q   <= (rd_state_d == RResp);
      if (ar_hs) begin
        rd_idx_q <= io_slave.araddr[IDX_W+1:2];
        rd_id_q  <= io_slave.arid;
        rd_err_q <= !in_window(io_slave.araddr, BASE_ADDR, SPAN) || (io_slave.arlen != 8'd0);
      end
      if (rd_load) begin
        rdata_q <= rd_err_q ? 32'd0 : mem[rd_idx_q];
        rresp_q <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------- write FSM
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    commit     = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        aw_have_d = aw_have_q | aw_hs;
        w_have_d  = w_have_q | w_hs;
        if (wr_draw) begin
          wr_state_d = WDelay;
          wr_cnt_d   = wr_delay;
        end
      end
      WDelay: begin
        if (wr_cnt_q == 3'd0) begin
          wr_state_d = WResp;
          commit     = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q - 3'd1;
        end
      end
      WResp: begin
        if (io_slave.bready) begin
          wr_state_d = WIdle;
          aw_have_d  = 1'b0;
          w_have_d   = 1'b0;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state_q <= WIdle;
      wr_cnt_q   <= 3'd0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_err_q   <= 1'b0;
      wr_id_q    <= 4'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      awready_q  <= (wr_state_d == WIdle) && !aw_have_d;
      wready_q   <= (wr_state_d == WIdle) && !w_have_d;
      bvalid_q   <= (wr_state_d == WResp);
      if (aw_hs) begin
        wr_idx_q <= io_slave.awaddr[IDX_W+1:2];
        wr_id_q  <= io_slave.awid;
        wr_err_q <= !in_window(io_slave.awaddr, BASE_ADDR, SPAN) || (io_slave.awlen != 8'd0);
      end
      if (w_hs) begin
        wdata_q <= io_slave.wdata;
        wstrb_q <= io_slave.wstrb;
      end
      if (commit) begin
        bresp_q <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Single write port; nonblocking update means a same-cycle read sees old data.
  always_ff @(posedge clock) begin
    if (commit && !wr_err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[wr_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign io_slave.arready = arready_q;
  assign io_slave.rvalid  = rvalid_q;
  assign io_slave.rdata   = rdata_q;
  assign io_slave.rresp   = rresp_q;
  assign io_slave.rlast   = rvalid_q;
  assign io_slave.rid     = rd_id_q;
  assign io_slave.awready = awready_q;
  assign io_slave.wready  = wready_q;
  assign io_slave.bvalid  = bvalid_q;
  assign io_slave.bresp   = bresp_q;
  assign io_slave.bid     = wr_id_q;

  // Single-beat slave: size, burst and wlast carry no information here.
  logic unused_ok;
  assign unused_ok = ^{io_slave.awsize, io_slave.awburst, io_slave.arsize, io_slave.arburst,
                       io_slave.wlast, lfsr[7:6], SIZE_B, SIZE_H, SIZE_W};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus randomized traffic
// checked against an associative-array memory and an LFSR-derived latency prediction.
module tb_axi_sram_slave;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  axi_sram_slave_if bus ();
  axi_sram_slave_if bus0 ();

  axi_sram_slave #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .DELAY_EN    (1'b1),
    .DELAY_MAX   (7)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_slave (bus)
  );

  axi_sram_slave #(
    .BASE_ADDR   (32'h8000_0000),
    .DEPTH_WORDS (4096),
    .DELAY_EN    (1'b0),
    .DELAY_MAX   (7)
  ) dut0 (
    .clock    (clock),
    .reset    (reset),
    .io_slave (bus0)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0]  lfsr_m = 8'hA5;
  logic [31:0] mem_m [int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Next delay the slave will draw: low three bits of the LFSR sequence.
  function automatic int draw();
    int d;
    d = int'(lfsr_m[2:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    return d;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 2);
  endfunction

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [3:0] rid, output logic rlast, output int lat);
    int t;
    @(negedge clock);
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arlen = len;
    t = 0;
    while (bus.arready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    check("ar_accept", 64'(bus.arready), 64'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
    lat = 0;
    while (bus.rvalid !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    data = bus.rdata; resp = bus.rresp; rid = bus.rid; rlast = bus.rlast;
    bus.rready = 1'b1;
    @(negedge clock);
    bus.rready = 1'b0;
    check("r_done", 64'({bus.rvalid, bus.arready}), 64'b01);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [31:0] data, input logic [3:0] strb, input int w_lead,
                           output logic [1:0] resp, output logic [3:0] bid, output int lat);
    bit aw_done, w_done, aw_hs, w_hs, early;
    int n;
    @(negedge clock);
    bus.awaddr = addr; bus.awid = id; bus.awlen = len;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = 1'b1;
    bus.wvalid = 1'b1;
    bus.awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; early = 0; n = 0;
    while (!(aw_done && w_done) && n < 100) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      if (bus.bvalid) early = 1;
      @(negedge clock);
      n++;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin bus.wvalid = 1'b0; w_done = 1; end
      if (w_hs && !aw_done) check("wready_drop", 64'(bus.wready), 64'd0);
      if (w_lead > 0 && n == w_lead) bus.awvalid = 1'b1;
    end
    check("no_early_b", 64'(early), 64'd0);
    lat = 0;
    while (bus.bvalid !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
    resp = bus.bresp; bid = bus.bid;
    bus.bready = 1'b1;
    @(negedge clock);
    bus.bready = 1'b0;
    check("b_done", 64'({bus.bvalid, bus.awready, bus.wready}), 64'b011);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [7:0] len);
    logic [31:0] d, exp_d;
    logic [1:0]  r, exp_r;
    logic [3:0]  id, rid;
    logic        rl;
    int          lat, exp_lat;
    id = 4'($urandom);
    exp_lat = 1 + draw();
    if (mapped(addr) && len == 8'd0) begin
      exp_d = mem_m[widx(addr)]; exp_r = 2'b00;
    end else begin
      exp_d = 32'd0; exp_r = 2'b10;
    end
    axi_read(addr, id, len, d, r, rid, rl, lat);
    check({tag, "_rdata"}, 64'(d), 64'(exp_d));
    check({tag, "_rresp"}, 64'(r), 64'(exp_r));
    check({tag, "_rid"}, 64'({rid, rl}), 64'({id, 1'b1}));
    check({tag, "_rlat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic wr_check(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] data, input logic [3:0] strb, input int w_lead);
    logic [1:0]  r, exp_r;
    logic [3:0]  id, bid;
    logic [31:0] w;
    int          lat, exp_lat;
    id = 4'($urandom);
    exp_lat = 1 + draw();
    exp_r = (mapped(addr) && len == 8'd0) ? 2'b00 : 2'b10;
    axi_write(addr, id, len, data, strb, w_lead, r, bid, lat);
    if (exp_r == 2'b00) begin
      w = mem_m.exists(widx(addr)) ? mem_m[widx(addr)] : 32'd0;
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
      mem_m[widx(addr)] = w;
    end
    check({tag, "_bresp"}, 64'(r), 64'(exp_r));
    check({tag, "_bid"}, 64'(bid), 64'(id));
    check({tag, "_blat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [31:0] addrs [6];
    logic [31:0] a;
    int t;

    {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} = '0;
    {bus.awaddr, bus.awid, bus.awlen, bus.awsize, bus.awburst} = '0;
    {bus.wdata, bus.wstrb, bus.wlast, bus.araddr, bus.arid, bus.arlen} = '0;
    {bus.arsize, bus.arburst} = '0;
    {bus0.awvalid, bus0.wvalid, bus0.bready, bus0.arvalid, bus0.rready} = '0;
    {bus0.awaddr, bus0.awid, bus0.awlen, bus0.awsize, bus0.awburst} = '0;
    {bus0.wdata, bus0.wstrb, bus0.wlast, bus0.araddr, bus0.arid, bus0.arlen} = '0;
    {bus0.arsize, bus0.arburst} = '0;

    // Reset state
    #12;
    check("reset_outs", 64'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                             bus.rdata, bus.bresp, bus.rresp, bus.bid, bus.rid}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 64'({bus.arready, bus.awready, bus.wready}), 64'b111);

    // Full word write then read back; byte-lane merge
    wr_check("t1w", 32'h8000_0004, 8'd0, 32'hDEADBEEF, 4'hF, 0);
    rd_check("t1r", 32'h8000_0004, 8'd0);
    wr_check("t2w", 32'h8000_0004, 8'd0, 32'h0000AA00, 4'b0010, 0);
    rd_check("t2r", 32'h8000_0004, 8'd0);
    check("t2_value", 64'(mem_m[1]), 64'h0000_0000_DEADAAEF);

    // W leads AW by two cycles
    wr_check("t3w", 32'h8000_0100, 8'd0, 32'h01234567, 4'hF, 2);
    rd_check("t3r", 32'h8000_0100, 8'd0);

    // Out-of-range and len != 0 produce SLVERR without touching memory
    wr_check("t4a", 32'h8000_1000, 8'd0, 32'hCAFEF00D, 4'hF, 0);
    rd_check("t4r_oor", 32'h0000_1000, 8'd0);
    wr_check("t4w_oor", 32'h0000_1000, 8'd0, 32'h11111111, 4'hF, 0);
    wr_check("t4w_len", 32'h8000_1000, 8'd1, 32'h22222222, 4'hF, 1);
    rd_check("t4r_len", 32'h8000_1000, 8'd3);
    rd_check("t4r_keep", 32'h8000_1000, 8'd0);
    rd_check("t4r_top", 32'h8000_4000, 8'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 32'h8000_0000 + 32'($urandom_range(0, 4095)) * 4;
      wr_check("rnd_full", addrs[i], 8'd0, $urandom, 4'hF, $urandom_range(0, 2));
    end
    for (int i = 0; i < 6; i++) begin
      wr_check("rnd_part", addrs[$urandom_range(0, 5)], 8'd0, $urandom,
               4'($urandom), $urandom_range(0, 2));
    end
    for (int i = 0; i < 6; i++) rd_check("rnd_rd", addrs[i], 8'd0);

    // No-delay instance: fixed latency and R held under backpressure
    @(negedge clock);
    bus0.awaddr = 32'h8000_0010; bus0.awid = 4'h3; bus0.awlen = 8'd0;
    bus0.wdata = 32'h12345678; bus0.wstrb = 4'hF;
    bus0.awvalid = 1'b1; bus0.wvalid = 1'b1;
    t = 0;
    while (!(bus0.awready && bus0.wready) && t < 20) begin @(negedge clock); t++; end
    @(negedge clock);
    bus0.awvalid = 1'b0; bus0.wvalid = 1'b0;
    t = 0;
    while (bus0.bvalid !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    check("t5_blat", 64'(t), 64'd1);
    bus0.bready = 1'b1;
    @(negedge clock);
    bus0.bready = 1'b0;
    bus0.araddr = 32'h8000_0010; bus0.arid = 4'h9; bus0.arlen = 8'd0;
    bus0.arvalid = 1'b1;
    t = 0;
    while (bus0.arready !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    @(negedge clock);
    bus0.arvalid = 1'b0;
    t = 0;
    while (bus0.rvalid !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    check("t5_rlat", 64'(t), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_hold", 64'({bus0.rvalid, bus0.arready, bus0.rdata, bus0.rid}),
            64'({1'b1, 1'b0, 32'h12345678, 4'h9}));
    end
    bus0.rready = 1'b1;
    @(negedge clock);
    bus0.rready = 1'b0;
    check("t5_release", 64'({bus0.rvalid, bus0.arready}), 64'b01);

    // Reset while a read waits
    @(negedge clock);
    bus.araddr = 32'h8000_0004; bus.arid = 4'h5; bus.arlen = 8'd0;
    bus.arvalid = 1'b1;
    t = 0;
    while (bus.arready !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    @(negedge clock);
    bus.arvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_rd_reset", 64'({bus.rvalid, bus.arready}), 64'd0);
    lfsr_m = 8'hA5;
    @(negedge clock);
    reset = 1'b1;

    // Reset while a write is delayed: the word must keep its old value
    @(negedge clock);
    a = 32'h8000_0100;
    bus.awaddr = a; bus.awid = 4'h6; bus.awlen = 8'd0;
    bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    t = 0;
    while (!(bus.awready && bus.wready) && t < 20) begin @(negedge clock); t++; end
    @(negedge clock);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_wr_reset", 64'({bus.bvalid, bus.awready, bus.wready}), 64'd0);
    lfsr_m = 8'hA5;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("t6_no_b", 64'(bus.bvalid), 64'd0);
    rd_check("t6_keep", a, 8'd0);
    wr_check("t6_next", a, 8'd0, 32'h5A5A_0F0F, 4'hF, 0);
    rd_check("t6_next", a, 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
